// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder (dmem_ctrl / dmem_array).
package dmem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_t;

   // Counter only ever holds LATENCY-1, so clog2(LATENCY) bits suffice (min 1).
   function automatic int cnt_width(input int latency);
      return (latency <= 1) ? 1 : $clog2(latency);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 synchronous RAM with registered, read-first output; no reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: fixed-latency access with pipeline stall and ack pulse.
// Optional misaligned-access suppression is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [31:0]       addr_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [WORD_W-1:0] data_o,
   output logic              stall_o,
   output logic              ack_o,
   output logic              misalign_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(LATENCY);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t            state;
   state_t            state_nxt;
   op_t               op_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;

   logic              req;
   logic              accept;
   logic              access;
   logic              mis_eff;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [WORD_W-1:0] rdata;

   logic              unused_addr;
   assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

   always_comb begin
      req        = MemRead_i | MemWrite_i;
      state_nxt  = state;
      accept     = 1'b0;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // While reset is asserted the state register is not yet IDLE, so force the IDLE rule.
      stall_o = (state == IDLE) ? req : (state == BUSY);
      if (rst_i) begin
         stall_o = req;
      end
      ack_o      = (state == DONE);
      misalign_o = (state == DONE) & mis_eff;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         data_o <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= CNT_INIT;
         end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (access && (op_q == OP_LOAD)) begin
            data_o <= mis_eff ? '0 : rdata;
         end
      end
   end

   // Capture registers hold the request for the whole access; both strobes high means store.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         idx_q   <= addr_i[IDX_W+1:2];
         wdata_q <= data_i;
         op_q    <= MemWrite_i ? OP_STORE : OP_LOAD;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic mis_q;
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mis_q <= (addr_i[1:0] != 2'b00);
      end
   end
   assign mis_eff = mis_q;
`else
   assign mis_eff = 1'b0;
`endif

   // The array reads from the live address in the accept cycle so the registered word is
   // already valid when the access edge arrives, even for LATENCY == 1.
   assign mem_idx = (state == IDLE) ? addr_i[IDX_W+1:2] : idx_q;
   assign mem_we  = access & (op_q == OP_STORE) & ~mis_eff;

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk_i),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a load-result scoreboard queue.
module tb_dmem_ctrl;

   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        stall_o;
   logic        ack_o;
   logic        misalign_o;

   always #5 clk = ~clk;

   dmem_ctrl #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .stall_o    (stall_o),
      .ack_o      (ack_o),
      .misalign_o (misalign_o)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];
   logic [31:0] last_load = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, then settle to mid-cycle.
   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      MemRead_i  = rd;
      MemWrite_i = wr;
      addr_i     = a;
      data_i     = d;
      #4;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, $urandom, $urandom);
         check({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
         check({tag, ".ack"}, {31'd0, ack_o}, 32'd0);
         check({tag, ".misalign"}, {31'd0, misalign_o}, 32'd0);
         check({tag, ".data"}, data_o, last_load);
      end
   endtask

   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      int          idx;
      bit          mis;
      logic [31:0] exp;
      logic [31:0] got_exp;
      idx = int'((a >> 2) % DEPTH);
      mis = ALIGN && (a[1:0] != 2'b00);
      if (wr) begin
         if (!mis) model[idx] = d;
         exp = last_load;
      end else begin
         exp = mis ? 32'h0 : model[idx];
      end
      last_load = exp;
      exp_q.push_back(exp);

      drive(rd, wr, a, d);
      check({tag, ".c0_stall"}, {31'd0, stall_o}, 32'd1);
      check({tag, ".c0_ack"}, {31'd0, ack_o}, 32'd0);
      for (int c = 1; c <= LATENCY; c++) begin
         drive(rd, wr, $urandom, $urandom);
         check({tag, ".busy_stall"}, {31'd0, stall_o}, 32'd1);
         check({tag, ".busy_ack"}, {31'd0, ack_o}, 32'd0);
      end
      drive(rd, wr, a, d);
      got_exp = exp_q.pop_front();
      check({tag, ".done_stall"}, {31'd0, stall_o}, 32'd0);
      check({tag, ".done_ack"}, {31'd0, ack_o}, 32'd1);
      check({tag, ".done_misalign"}, {31'd0, misalign_o}, {31'd0, mis});
      check({tag, ".done_data"}, data_o, got_exp);
   endtask

   initial begin
      rst_i      = 1'b1;
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      addr_i     = 32'h0;
      data_i     = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      idle(3, "reset_idle");

      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
      access(1'b1, 1'b0, 32'h10, 32'h0, "ld_10");
      idle(1, "gap1");

      access(1'b0, 1'b1, 32'h404, 32'h1234, "st_404");
      access(1'b1, 1'b0, 32'h4, 32'h0, "ld_4");

      access(1'b1, 1'b1, 32'h20, 32'h55, "both_20");
      access(1'b1, 1'b0, 32'h20, 32'h0, "ld_20");
      idle(1, "gap2");

      // Reset in the middle of a store must discard it.
      access(1'b0, 1'b1, 32'h30, 32'h1111, "st_30");
      drive(1'b0, 1'b1, 32'h30, 32'hAAAA);
      check("abort.c0_stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      rst_i      = 1'b1;
      MemWrite_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      #4;
      last_load = 32'h0;
      check("abort.stall", {31'd0, stall_o}, 32'd0);
      check("abort.ack", {31'd0, ack_o}, 32'd0);
      check("abort.data", data_o, 32'h0);
      idle(2, "abort_idle");
      access(1'b1, 1'b0, 32'h30, 32'h0, "ld_30");

      access(1'b1, 1'b0, 32'h13, 32'h0, "ld_13");
      access(1'b0, 1'b1, 32'h13, 32'h77, "st_13");
      access(1'b1, 1'b0, 32'h10, 32'h0, "ld_10b");
      idle(2, "tail");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
